// File: rtl/if_window_loader_pkg.sv
// Shared types for the IF window loader: FSM states, window FIFO entry, ring pointer increment.
package if_window_loader_pkg;

    // Entry field width; the loader's ADDR_LEN must not exceed this.
    localparam int WIN_ADDR_LEN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FILL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIN_ADDR_LEN-1:0] start_addr;
        logic [WIN_ADDR_LEN-1:0] end_addr;
    } win_entry_t;

    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        int unsigned nxt;
        nxt = ptr + 1;
        return (nxt >= depth) ? 0 : nxt;
    endfunction

endpackage

// File: rtl/if_win_fifo.sv
// NUM_WIN-deep FIFO of window descriptors with a registered head entry.
module if_win_fifo
    import if_window_loader_pkg::*;
#(
    parameter int NUM_WIN     = 4,
    parameter int WIN_IDX_LEN = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  win_entry_t           din,
    output win_entry_t           head,
    output logic [WIN_IDX_LEN:0] count
);

    localparam logic [WIN_IDX_LEN:0] FULL_CNT = (WIN_IDX_LEN+1)'(NUM_WIN);
    localparam logic [WIN_IDX_LEN:0] ONE_CNT  = (WIN_IDX_LEN+1)'(1);

    win_entry_t             mem [NUM_WIN];
    logic [WIN_IDX_LEN-1:0] rd_ptr;
    logic [WIN_IDX_LEN-1:0] wr_ptr;
    logic [WIN_IDX_LEN-1:0] rd_next;
    logic                   do_push;
    logic                   do_pop;

    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != FULL_CNT) | do_pop);
    assign rd_next = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // The head register must already show the next entry when a pop lands,
    // including the case where that entry is the one being pushed this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_next;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
            if (do_pop) begin
                if (count > ONE_CNT) head <= mem[rd_next];
                else if (do_push)    head <= din;
            end else if (do_push && count == '0) begin
                head <= din;
            end
        end
    end

endmodule

// File: rtl/if_window_loader.sv
// Drains the IF buffer into a circular scratchpad holding up to NUM_WIN complete windows.
// Define IF_LEVEL_EN to add the registered fill_level output.
module if_window_loader
    import if_window_loader_pkg::*;
#(
    parameter int ADDR_LEN      = 8,
    parameter int SCRATCH_DEPTH = 256,
    parameter int NUM_WIN       = 4,
    parameter int WIN_IDX_LEN   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 buf_empty,
    input  logic                 buf_end_flag,
    output logic                 buf_read,
    output logic                 scratch_wen,
    output logic [ADDR_LEN-1:0]  scratch_waddr,
    output logic                 win_valid,
    output logic [ADDR_LEN-1:0]  win_start,
    output logic [ADDR_LEN-1:0]  win_end,
    input  logic                 win_pop,
    output logic [WIN_IDX_LEN:0] win_count,
`ifdef IF_LEVEL_EN
    output logic [ADDR_LEN:0]    fill_level,
`endif
    output logic                 stall
);

    localparam logic [WIN_IDX_LEN:0] FULL_CNT = (WIN_IDX_LEN+1)'(NUM_WIN);
    localparam logic [WIN_IDX_LEN:0] ONE_CNT  = (WIN_IDX_LEN+1)'(1);

    function automatic logic [ADDR_LEN-1:0] ring_inc(input logic [ADDR_LEN-1:0] p);
        return ADDR_LEN'(wrap_inc(32'(p), SCRATCH_DEPTH));
    endfunction

    state_t                state;
    logic [ADDR_LEN-1:0]   waddr;
    logic [ADDR_LEN-1:0]   base;
    logic [ADDR_LEN-1:0]   open_start;
    logic [ADDR_LEN-1:0]   waddr_nxt;
    logic [ADDR_LEN-1:0]   base_nxt;
    logic [ADDR_LEN-1:0]   open_nxt;
    win_entry_t            head;
    win_entry_t            new_entry;
    logic [WIN_IDX_LEN:0]  count;
    logic                  in_fill;
    logic                  in_clear;
    logic                  ring_full;
    logic                  fifo_full;
    logic                  pop_eff;
    logic                  wr;
    logic                  push;

    assign in_fill   = (state == FILL);
    assign in_clear  = (state == CLEAR);
    assign ring_full = (ring_inc(waddr) == base);
    assign fifo_full = (count == FULL_CNT);

    // A start request wins the cycle, so neither a write nor a pop may commit alongside it.
    assign pop_eff = win_pop & win_valid & in_fill & ~start;
    assign wr      = in_fill & ~start & ~buf_empty & ~ring_full
                   & ~(buf_end_flag & fifo_full & ~pop_eff);
    assign push    = wr & buf_end_flag;

    assign buf_read      = wr;
    assign scratch_wen   = wr;
    assign scratch_waddr = waddr;
    assign stall         = in_fill & ~buf_empty & ~wr;
    assign win_valid     = (count != '0);
    assign win_count     = count;
    assign win_start     = ADDR_LEN'(head.start_addr);
    assign win_end       = ADDR_LEN'(head.end_addr);

    assign new_entry.start_addr = WIN_ADDR_LEN'(open_start);
    assign new_entry.end_addr   = WIN_ADDR_LEN'(waddr);

    if_win_fifo #(
        .NUM_WIN     (NUM_WIN),
        .WIN_IDX_LEN (WIN_IDX_LEN)
    ) u_win_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (in_clear),
        .push  (push),
        .pop   (pop_eff),
        .din   (new_entry),
        .head  (head),
        .count (count)
    );

    // Releasing the last window hands everything up to the open window back to the ring.
    always_comb begin
        waddr_nxt = waddr;
        base_nxt  = base;
        open_nxt  = open_start;
        if (in_clear) begin
            waddr_nxt = '0;
            base_nxt  = '0;
            open_nxt  = '0;
        end else begin
            if (wr)   waddr_nxt = ring_inc(waddr);
            if (push) open_nxt  = ring_inc(waddr);
            if (pop_eff) begin
                if (count == ONE_CNT && !push) base_nxt = open_start;
                else                          base_nxt = ring_inc(ADDR_LEN'(head.end_addr));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            waddr      <= '0;
            base       <= '0;
            open_start <= '0;
        end else begin
            waddr      <= waddr_nxt;
            base       <= base_nxt;
            open_start <= open_nxt;
            if (start) begin
                state <= CLEAR;
            end else begin
                case (state)
                    IDLE:    state <= IDLE;
                    CLEAR:   state <= FILL;
                    FILL:    state <= FILL;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef IF_LEVEL_EN
    localparam logic [ADDR_LEN:0] DEPTH_W = (ADDR_LEN+1)'(SCRATCH_DEPTH);

    logic [ADDR_LEN:0] level_nxt;

    always_comb begin
        level_nxt = {1'b0, waddr_nxt} + DEPTH_W - {1'b0, base_nxt};
        if (level_nxt >= DEPTH_W) level_nxt = level_nxt - DEPTH_W;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fill_level <= '0;
        else        fill_level <= level_nxt;
    end
`endif

endmodule

// File: tb/tb_if_window_loader.sv
// Self-checking bench for if_window_loader: directed vector table, corner sequences, random run vs model.
module tb_if_window_loader;

    localparam int D  = 8;
    localparam int NW = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       buf_empty;
    logic       buf_end_flag;
    logic       buf_read;
    logic       scratch_wen;
    logic [7:0] scratch_waddr;
    logic       win_valid;
    logic [7:0] win_start;
    logic [7:0] win_end;
    logic       win_pop;
    logic [1:0] win_count;
    logic       stall;
`ifdef IF_LEVEL_EN
    logic [8:0] fill_level;
`endif

    if_window_loader #(
        .ADDR_LEN      (8),
        .SCRATCH_DEPTH (D),
        .NUM_WIN       (NW),
        .WIN_IDX_LEN   (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .buf_empty     (buf_empty),
        .buf_end_flag  (buf_end_flag),
        .buf_read      (buf_read),
        .scratch_wen   (scratch_wen),
        .scratch_waddr (scratch_waddr),
        .win_valid     (win_valid),
        .win_start     (win_start),
        .win_end       (win_end),
        .win_pop       (win_pop),
        .win_count     (win_count),
`ifdef IF_LEVEL_EN
        .fill_level    (fill_level),
`endif
        .stall         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 clear, 2 fill; windows kept as a queue of address ranges
    typedef struct { int s; int e; } win_t;
    win_t mq[$];
    int   m_phase;
    int   m_waddr;
    int   m_base;
    int   m_open;
    bit   c_empty, c_end, c_pop, c_st;
    bit   p_wr, p_pop;

    typedef struct {
        bit empty; bit end_flag; bit pop; bit st;
        bit e_rd; bit e_valid; int e_start; int e_end; int e_count; bit e_stall; int e_waddr; int e_level;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_phase = 0; m_waddr = 0; m_base = 0; m_open = 0;
        mq.delete();
    endtask

    task automatic driveInputs(input bit e, input bit f, input bit p, input bit s);
        @(negedge clk);
        buf_empty = e; buf_end_flag = f; win_pop = p; start = s;
        c_empty = e; c_end = f; c_pop = p; c_st = s;
        #1;
    endtask

    task automatic checkOutput();
        bit in_fill;
        bit rfull;
        in_fill = (m_phase == 2);
        p_pop   = c_pop && mq.size() > 0 && in_fill && !c_st;
        rfull   = ((m_waddr + 1) % D) == m_base;
        p_wr    = in_fill && !c_st && !c_empty && !rfull && !(c_end && mq.size() == NW && !p_pop);
        check("buf_read", buf_read, p_wr);
        check("scratch_wen", scratch_wen, p_wr);
        if (p_wr) check("scratch_waddr", scratch_waddr, m_waddr);
        check("stall", stall, in_fill && !c_empty && !p_wr);
        check("win_valid", win_valid, mq.size() > 0);
        check("win_count", win_count, mq.size());
        if (mq.size() > 0) begin
            check("win_start", win_start, mq[0].s);
            check("win_end", win_end, mq[0].e);
        end
`ifdef IF_LEVEL_EN
        check("fill_level", fill_level, (m_waddr - m_base + D) % D);
`endif
    endtask

    task automatic advance();
        win_t h;
        @(posedge clk);
        if (m_phase == 1) begin
            m_waddr = 0; m_base = 0; m_open = 0;
            mq.delete();
        end else if (m_phase == 2) begin
            if (p_wr && c_end) begin
                mq.push_back('{m_open, m_waddr});
                m_open = (m_waddr + 1) % D;
            end
            if (p_wr) m_waddr = (m_waddr + 1) % D;
            if (p_pop) begin
                h = mq.pop_front();
                m_base = (mq.size() == 0) ? m_open : (h.e + 1) % D;
            end
        end
        m_phase = c_st ? 1 : ((m_phase == 1) ? 2 : m_phase);
    endtask

    task automatic applyStimulus(input bit e, input bit f, input bit p, input bit s);
        driveInputs(e, f, p, s);
        checkOutput();
        advance();
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " buf_read"}, buf_read, 0);
        check({tag, " scratch_wen"}, scratch_wen, 0);
        check({tag, " scratch_waddr"}, scratch_waddr, 0);
        check({tag, " win_valid"}, win_valid, 0);
        check({tag, " win_start"}, win_start, 0);
        check({tag, " win_end"}, win_end, 0);
        check({tag, " win_count"}, win_count, 0);
        check({tag, " stall"}, stall, 0);
`ifdef IF_LEVEL_EN
        check({tag, " fill_level"}, fill_level, 0);
`endif
    endtask

    int wr_seen;
    int exp_addr[4] = '{6, 7, 0, 1};

    initial begin
        //          empty end pop st | rd valid start end count stall waddr level
        vecs[0]  = '{1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 1};
        vecs[4]  = '{0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 2, 2};
        vecs[5]  = '{0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 3, 3};
        vecs[6]  = '{0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 4, 4};
        vecs[7]  = '{1, 0, 0, 0,  0, 1, 0, 4, 1, 0, 0, 5};
        vecs[8]  = '{1, 0, 1, 0,  0, 1, 0, 4, 1, 0, 0, 5};
        vecs[9]  = '{1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 5, 0};
        vecs[11] = '{1, 0, 0, 0,  0, 1, 5, 5, 1, 0, 0, 1};

        rst_n = 1'b0; start = 0; buf_empty = 1; buf_end_flag = 0; win_pop = 0;
        modelReset();
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic window / ignored pop table");
        for (int i = 0; i < 12; i++) begin
            driveInputs(vecs[i].empty, vecs[i].end_flag, vecs[i].pop, vecs[i].st);
            checkOutput();
            check($sformatf("vec%0d buf_read", i), buf_read, vecs[i].e_rd);
            check($sformatf("vec%0d win_valid", i), win_valid, vecs[i].e_valid);
            check($sformatf("vec%0d win_count", i), win_count, vecs[i].e_count);
            check($sformatf("vec%0d stall", i), stall, vecs[i].e_stall);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d win_start", i), win_start, vecs[i].e_start);
                check($sformatf("vec%0d win_end", i), win_end, vecs[i].e_end);
            end
            if (vecs[i].e_rd) check($sformatf("vec%0d scratch_waddr", i), scratch_waddr, vecs[i].e_waddr);
`ifdef IF_LEVEL_EN
            check($sformatf("vec%0d fill_level", i), fill_level, vecs[i].e_level);
`endif
            advance();
        end

        $display("[TB] wrap-around");
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 3; k++) applyStimulus(0, k == 2, 0, 0);
        applyStimulus(1, 0, 1, 0);
`ifdef IF_LEVEL_EN
        driveInputs(1, 0, 0, 0);
        check("wrap fill_level after pop", fill_level, 3);
        checkOutput();
        advance();
`endif
        for (int k = 0; k < 4; k++) begin
            driveInputs(0, k == 3, 0, 0);
            check($sformatf("wrap write %0d addr", k), scratch_waddr, exp_addr[k]);
            check($sformatf("wrap write %0d read", k), buf_read, 1);
            checkOutput();
            advance();
        end
        driveInputs(1, 0, 1, 0);
        check("wrap head start", win_start, 3);
        check("wrap head end", win_end, 5);
        check("wrap count", win_count, 2);
        checkOutput();
        advance();
        driveInputs(1, 0, 0, 0);
        check("wrap entry start", win_start, 6);
        check("wrap entry end", win_end, 1);
        checkOutput();
        advance();

        $display("[TB] ring full then start mid-window");
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        wr_seen = 0;
        for (int k = 0; k < 10; k++) begin
            driveInputs(0, 0, 0, 0);
            if (buf_read) wr_seen++;
            checkOutput();
            advance();
        end
        check("ring full write count", wr_seen, 7);
        driveInputs(0, 0, 0, 0);
        check("ring full stall", stall, 1);
        check("ring full buf_read", buf_read, 0);
        check("ring full waddr", scratch_waddr, 7);
        checkOutput();
        advance();
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        driveInputs(0, 0, 0, 0);
        check("restart buf_read", buf_read, 1);
        check("restart waddr", scratch_waddr, 0);
        checkOutput();
        advance();

        $display("[TB] window FIFO full");
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            driveInputs(0, 1, 0, 0);
            check("fifo full held", buf_read, 0);
            check("fifo full stall", stall, 1);
            check("fifo full count", win_count, 2);
            checkOutput();
            advance();
        end
        driveInputs(0, 1, 1, 0);
        check("push+pop buf_read", buf_read, 1);
        check("push+pop waddr", scratch_waddr, 2);
        checkOutput();
        advance();
        driveInputs(1, 0, 0, 0);
        check("push+pop count", win_count, 2);
        check("push+pop head start", win_start, 1);
        check("push+pop head end", win_end, 1);
        checkOutput();
        advance();

        $display("[TB] reset mid-write");
        driveInputs(0, 0, 0, 0);
        check("pre-reset buf_read", buf_read, 1);
        rst_n = 1'b0;
        #1;
        checkAllZero("async reset");
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] random run");
        applyStimulus(1, 0, 0, 1);
        for (int n = 0; n < 800; n++) begin
            applyStimulus($urandom_range(0, 9) < 3,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) < 3,
                          $urandom_range(0, 49) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
